// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Samples the synchronized line near each bit centre using the rx_baud_os tick.
module uart_rx #(
    parameter int OVS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_baud_os,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(OVS);
    // The entry tick already counts as tick 0, so the mid-start sample lands
    // OVS/2-1 ticks after entry; every later sample is a full OVS apart.
    localparam logic [CW-1:0] START_LAST = CW'(OVS / 2 - 2);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic          rx_meta_r;
    logic          rx_sync_r;
    logic          rx_s;
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          par_bit_r;
    logic [7:0]    data_out_r;
    logic          rx_valid_r;
    logic          parity_err_r;
    logic          frame_err_r;

    assign rx_s       = rx_sync_r;
    assign data_out   = data_out_r;
    assign rx_valid   = rx_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign rx_busy    = (state_r != IDLE);

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame FSM with tick counter, shift register and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            par_bit_r    <= 1'b0;
            data_out_r   <= 8'h00;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if (rx_baud_os) begin
                case (state_r)
                    IDLE: begin
                        if (!rx_s) begin
                            state_r <= START;
                            cnt_r   <= {CW{1'b0}};
                        end
                    end
                    START: begin
                        if (cnt_r == START_LAST) begin
                            if (rx_s) begin
                                state_r <= IDLE;
                            end else begin
                                cnt_r     <= {CW{1'b0}};
                                bit_idx_r <= 3'd0;
                                state_r   <= DATA;
                            end
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_r == BIT_LAST) begin
                            shift_r[bit_idx_r] <= rx_s;
                            cnt_r              <= {CW{1'b0}};
                            if (bit_idx_r == 3'd7) begin
                                state_r <= PARITY;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    PARITY: begin
                        if (cnt_r == BIT_LAST) begin
                            par_bit_r <= rx_s;
                            cnt_r     <= {CW{1'b0}};
                            state_r   <= STOP;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    STOP: begin
                        if (cnt_r == BIT_LAST) begin
                            data_out_r   <= shift_r;
                            parity_err_r <= par_bit_r ^ even_parity(shift_r);
                            frame_err_r  <= ~rx_s;
                            rx_valid_r   <= 1'b1;
                            cnt_r        <= {CW{1'b0}};
                            // A low stop bit may be a break; wait for the line to recover.
                            state_r      <= rx_s ? IDLE : WAIT_HIGH;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx_s) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= {CW{1'b0}};
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVS, 16, rx_baud_os ticks per bit; even, 8..64.
REQ-002 Port: clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: rx  in  1  serial line, idle high; asynchronous to clock.
REQ-005 Port: rx_baud_os  in  1  one-clock enable pulse at OVS times the bit rate.
REQ-006 Port: data_out  out  8  last received data byte.
REQ-007 Port: rx_valid  out  1  one-clock pulse when a frame is complete.
REQ-008 Port: parity_err  out  1  status of the last frame: received parity bit != ^data_out.
REQ-009 Port: frame_err  out  1  status of the last frame: stop bit sampled 0.
REQ-010 Port: rx_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 The frame format SHALL be: start 0, data bits 0..7 LSB first, one even-parity bit (XOR of the 8 data bits), stop 1.
REQ-012 rx SHALL pass through a two-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-013 The tick counter and all FSM transitions SHALL advance only on cycles with rx_baud_os=1; other cycles hold state.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-015 IDLE: on a tick with rx_s=0, go to START and set tick count to 0.
REQ-016 START: when the tick count reaches OVS/2-1, sample rx_s; if 1 (glitch), return to IDLE with no outputs changed; if 0, clear count, clear bit index, go to DATA.
REQ-017 DATA: every OVS ticks (count = OVS-1), sample rx_s into shift register bit[index] and increment index; after index 7 is sampled, go to PARITY.
REQ-018 PARITY: sample rx_s at count OVS-1 and go to STOP.
REQ-019 STOP: sample rx_s at count OVS-1.
REQ-020 On the STOP sample, the following SHALL update on the same edge: data_out = shift register; parity_err = sampled parity XOR (^data); frame_err = NOT stop sample; rx_valid = 1.
REQ-021 rx_valid SHALL be high for exactly one clock; data_out, parity_err and frame_err hold until the next rx_valid.
REQ-022 After STOP, the FSM SHALL go to IDLE if the stop sample was 1, else to WAIT_HIGH.
REQ-023 WAIT_HIGH SHALL go to IDLE on the first tick with rx_s=1; a held-low line (break) therefore produces exactly one frame_err frame.
REQ-024 A frame with both errors SHALL assert both parity_err and frame_err with rx_valid.
REQ-025 Frame length: from the START entry tick, the stop sample occurs OVS/2-1 + 10*OVS ticks later.
REQ-026 rx_busy SHALL be a registered or pure decode of state != IDLE.

Reset
REQ-027 Asserting reset SHALL immediately set: state IDLE, counters 0, synchronizer flops 1, data_out 0x00, rx_valid 0, parity_err 0, frame_err 0, rx_busy 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without a rx_valid pulse; reception resumes on the next falling edge after release.

Verification
REQ-029 Frame 0xA5 (parity 0, stop 1), OVS=16 -> one rx_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, rx_busy low afterwards.
REQ-030 Frame 0x01 with the parity bit forced to 0 -> rx_valid, data_out=0x01, parity_err=1, frame_err=0.
REQ-031 Frame 0x3C with stop forced to 0 and the line then held low for 30 bit times -> exactly one rx_valid with frame_err=1; no further frames until rx goes high, after which 0x55 is received cleanly.
REQ-032 rx low pulse of 4 ticks -> no rx_valid; FSM back in IDLE; a following frame 0xFF is received cleanly.
REQ-033 Reset pulsed during data bit 4 of 0x96 -> no rx_valid; all outputs zero; the next frame 0x69 is received correctly.
REQ-034 Back-to-back frames 0x00, 0xFF, 0x80 with no idle gap, plus a gap of 7 non-tick clocks between ticks -> three rx_valid pulses in order with correct data and no errors.
